// File: rtl/proc_io_pkg.sv
// Shared defaults and helpers for the processor I/O hub and its stream FIFOs.
package proc_io_pkg;

  localparam int DEF_NUIOIN = 4;
  localparam int DEF_NUIOOU = 4;
  localparam int DEF_NBIN   = 19;
  localparam int DEF_NBOUT  = 28;
  localparam int DEF_FDEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Lowest bit of port idx inside a packed multi-port bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Single-clock stream FIFO; pointers carry one extra wrap bit to tell full from empty.
module io_sync_fifo
  import proc_io_pkg::*;
#(
  parameter int NB    = DEF_NBIN,
  parameter int DEPTH = DEF_FDEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [NB-1:0] din,
  output logic [NB-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]   r_wrPtr;
  logic [AW:0]   r_rdPtr;
  logic [NB-1:0] r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_wrPtr == r_rdPtr);
  assign full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rdPtr <= r_rdPtr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage needs no reset: emptied pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/proc_io_hub.sv
// Host-side endpoint for the float processor's port-mapped I/O strobes.
// Sticky underflow/overflow flags are built only when PROC_IO_HUB_ERR_EN is defined.
module proc_io_hub
  import proc_io_pkg::*;
#(
  parameter int NUIOIN = DEF_NUIOIN,
  parameter int NUIOOU = DEF_NUIOOU,
  parameter int NBIN   = DEF_NBIN,
  parameter int NBOUT  = DEF_NBOUT,
  parameter int FDEPTH = DEF_FDEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUIOIN*NBIN-1:0]  s_data,
  input  logic [NUIOIN-1:0]       s_valid,
  output logic [NUIOIN-1:0]       s_ready,
  input  logic [NUIOIN-1:0]       req_in,
  output logic [NBIN-1:0]         io_in,
  input  logic [NUIOOU-1:0]       out_en,
  input  logic [NBOUT-1:0]        io_out,
  output logic [NUIOOU*NBOUT-1:0] m_data,
  output logic [NUIOOU-1:0]       m_valid,
  input  logic [NUIOOU-1:0]       m_ready,
  input  logic                    err_clr,
  output logic [NUIOIN-1:0]       underflow,
  output logic [NUIOOU-1:0]       overflow
);

  logic [NUIOIN-1:0]            w_full;
  logic [NUIOIN-1:0]            w_empty;
  logic [NUIOIN-1:0]            w_push;
  logic [NUIOIN-1:0]            w_pop;
  logic [NUIOIN-1:0]            w_rdGnt;
  logic [NUIOOU-1:0]            w_wrGnt;
  logic [NUIOIN-1:0]            w_undEvt;
  logic [NUIOOU-1:0]            w_ovfEvt;
  logic [NUIOIN-1:0][NBIN-1:0]  w_dout;
  logic [NBIN-1:0]              w_ioIn;
  logic [NUIOIN-1:0][NBIN-1:0]  r_hold;
  logic [NUIOOU-1:0][NBOUT-1:0] r_mData;
  logic [NUIOOU-1:0]            r_mValid;

  // Isolating the lowest set bit serves non-one-hot strobes by lowest index.
  assign w_rdGnt  = req_in & (~req_in + NUIOIN'(1));
  assign w_wrGnt  = out_en & (~out_en + NUIOOU'(1));

  assign w_push   = s_valid & ~w_full;
  assign w_pop    = w_rdGnt & ~w_empty;
  assign w_undEvt = w_rdGnt & w_empty;
  assign w_ovfEvt = w_wrGnt & r_mValid & ~m_ready;

  assign s_ready  = ~w_full;
  assign io_in    = w_ioIn;
  assign m_data   = r_mData;
  assign m_valid  = r_mValid;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_fifo
    io_sync_fifo #(
      .NB    (NBIN),
      .DEPTH (FDEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[k]),
      .pop   (w_pop[k]),
      .din   (s_data[slice_lo(k, NBIN) +: NBIN]),
      .dout  (w_dout[k]),
      .full  (w_full[k]),
      .empty (w_empty[k])
    );
  end

  always_comb begin
    w_ioIn = '0;
    for (int k = 0; k < NUIOIN; k++) begin
      if (w_rdGnt[k]) w_ioIn = w_empty[k] ? r_hold[k] : w_dout[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
    end else begin
      for (int k = 0; k < NUIOIN; k++) begin
        if (w_pop[k]) r_hold[k] <= w_dout[k];
      end
    end
  end

  // A fresh strobe always wins, so a word loaded alongside a handshake keeps valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mData  <= '0;
      r_mValid <= '0;
    end else begin
      for (int k = 0; k < NUIOOU; k++) begin
        if (w_wrGnt[k]) begin
          r_mData[k]  <= io_out;
          r_mValid[k] <= 1'b1;
        end else if (r_mValid[k] && m_ready[k]) begin
          r_mValid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef PROC_IO_HUB_ERR_EN
  logic [NUIOIN-1:0] r_underflow;
  logic [NUIOOU-1:0] r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow <= '0;
      r_overflow  <= '0;
    end else begin
      r_underflow <= (err_clr ? '0 : r_underflow) | w_undEvt;
      r_overflow  <= (err_clr ? '0 : r_overflow) | w_ovfEvt;
    end
  end

  assign underflow = r_underflow;
  assign overflow  = r_overflow;
`else
  logic w_unusedErr;

  assign w_unusedErr = &{1'b0, err_clr, w_undEvt, w_ovfEvt};
  assign underflow   = '0;
  assign overflow    = '0;
`endif

endmodule

// File: tb/tb_proc_io_hub.sv
// Directed self-checking bench for proc_io_hub; flag expectations follow PROC_IO_HUB_ERR_EN.
module tb_proc_io_hub;

`ifdef PROC_IO_HUB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int BI = 19;
  localparam int BO = 28;

  logic              clk;
  logic              rst;
  logic [NI*BI-1:0]  s_data;
  logic [NI-1:0]     s_valid;
  logic [NI-1:0]     s_ready;
  logic [NI-1:0]     req_in;
  logic [BI-1:0]     io_in;
  logic [NO-1:0]     out_en;
  logic [BO-1:0]     io_out;
  logic [NO*BO-1:0]  m_data;
  logic [NO-1:0]     m_valid;
  logic [NO-1:0]     m_ready;
  logic              err_clr;
  logic [NI-1:0]     underflow;
  logic [NO-1:0]     overflow;

  int nChecks;
  int nErrors;

  proc_io_hub dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .req_in    (req_in),
    .io_in     (io_in),
    .out_en    (out_en),
    .io_out    (io_out),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_clr   (err_clr),
    .underflow (underflow),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    nChecks++;
    if (s_ready !== 4'hF || m_valid !== 4'h0 || io_in !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_outputs: s_ready=%h m_valid=%h io_in=%h expected F 0 0", s_ready, m_valid, io_in);
    end
    nChecks++;
    if (underflow !== 4'h0 || overflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL reset_flags: underflow=%h overflow=%h expected 0 0", underflow, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_sequence();
    logic [BI-1:0] words [3];
    words[0] = 19'd100;
    words[1] = 19'h7FFFB;
    words[2] = 19'd7;
    for (int i = 0; i < 3; i++) begin
      s_valid = 4'b0010;
      s_data[BI +: BI] = words[i];
      tick();
    end
    s_valid = 4'b0000;
    req_in = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      nChecks++;
      if (io_in !== words[i]) begin
        nErrors++;
        $display("[TB] FAIL read_word%0d: io_in=%h expected %h", i, io_in, words[i]);
      end
      tick();
    end
    nChecks++;
    if (io_in !== 19'd7 || underflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL read_empty_hold: io_in=%h underflow=%h expected 7 0", io_in, underflow);
    end
    tick();
    nChecks++;
    if (underflow !== (ERR_EN ? 4'b0010 : 4'b0000)) begin
      nErrors++;
      $display("[TB] FAIL underflow_set: underflow=%h expected %h", underflow, ERR_EN ? 4'b0010 : 4'b0000);
    end
    req_in = 4'b0000;
    #1;
    nChecks++;
    if (io_in !== '0) begin
      nErrors++;
      $display("[TB] FAIL idle_io_in: io_in=%h expected 0", io_in);
    end
    clear_flags();
    nChecks++;
    if (underflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL underflow_clear: underflow=%h expected 0", underflow);
    end
  endtask

  task automatic test_full();
    s_valid = 4'b0001;
    for (int i = 1; i <= 4; i++) begin
      s_data[0 +: BI] = BI'(i);
      tick();
    end
    nChecks++;
    if (s_ready !== 4'b1110) begin
      nErrors++;
      $display("[TB] FAIL full_ready: s_ready=%h expected e", s_ready);
    end
    s_data[0 +: BI] = 19'd5;
    tick();
    s_valid = 4'b0000;
    req_in = 4'b0001;
    #1;
    nChecks++;
    if (io_in !== 19'd1) begin
      nErrors++;
      $display("[TB] FAIL full_head: io_in=%h expected 1", io_in);
    end
    tick();
    nChecks++;
    if (s_ready !== 4'hF) begin
      nErrors++;
      $display("[TB] FAIL ready_after_pop: s_ready=%h expected f", s_ready);
    end
    for (int i = 2; i <= 4; i++) begin
      nChecks++;
      if (io_in !== BI'(i)) begin
        nErrors++;
        $display("[TB] FAIL drain_word%0d: io_in=%h expected %h", i, io_in, BI'(i));
      end
      tick();
    end
    nChecks++;
    if (io_in !== 19'd4) begin
      nErrors++;
      $display("[TB] FAIL fifth_dropped: io_in=%h expected 4", io_in);
    end
    tick();
    nChecks++;
    if (underflow !== (ERR_EN ? 4'b0001 : 4'b0000)) begin
      nErrors++;
      $display("[TB] FAIL underflow_port0: underflow=%h expected %h", underflow, ERR_EN ? 4'b0001 : 4'b0000);
    end
    req_in = 4'b0000;
    clear_flags();
  endtask

  task automatic test_capture();
    m_ready = 4'b0000;
    out_en = 4'b0100;
    io_out = 28'h0ABCDEF;
    tick();
    nChecks++;
    if (m_valid !== 4'b0100 || m_data[2*BO +: BO] !== 28'h0ABCDEF || overflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL capture_first: m_valid=%h slice2=%h overflow=%h expected 4 0abcdef 0", m_valid, m_data[2*BO +: BO], overflow);
    end
    io_out = 28'h0000001;
    tick();
    out_en = 4'b0000;
    nChecks++;
    if (m_data[2*BO +: BO] !== 28'h0000001 || overflow !== (ERR_EN ? 4'b0100 : 4'b0000)) begin
      nErrors++;
      $display("[TB] FAIL capture_overwrite: slice2=%h overflow=%h expected 1 %h", m_data[2*BO +: BO], overflow, ERR_EN ? 4'b0100 : 4'b0000);
    end
    m_ready = 4'b0100;
    tick();
    m_ready = 4'b0000;
    nChecks++;
    if (m_valid !== 4'b0000) begin
      nErrors++;
      $display("[TB] FAIL capture_drain: m_valid=%h expected 0", m_valid);
    end
    clear_flags();
    nChecks++;
    if (overflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL overflow_clear: overflow=%h expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    out_en = 4'b1000;
    io_out = 28'h1234567;
    tick();
    m_ready = 4'b1000;
    io_out = 28'h7654321;
    tick();
    out_en = 4'b0000;
    nChecks++;
    if (m_valid[3] !== 1'b1 || m_data[3*BO +: BO] !== 28'h7654321 || overflow[3] !== 1'b0) begin
      nErrors++;
      $display("[TB] FAIL back_to_back: m_valid3=%b slice3=%h overflow3=%b expected 1 7654321 0", m_valid[3], m_data[3*BO +: BO], overflow[3]);
    end
    tick();
    m_ready = 4'b0000;
    nChecks++;
    if (m_valid !== 4'b0000) begin
      nErrors++;
      $display("[TB] FAIL back_to_back_drain: m_valid=%h expected 0", m_valid);
    end
  endtask

  task automatic test_non_onehot();
    out_en = 4'b0110;
    io_out = 28'h0000055;
    tick();
    out_en = 4'b0000;
    nChecks++;
    if (m_valid !== 4'b0010 || m_data[BO +: BO] !== 28'h0000055) begin
      nErrors++;
      $display("[TB] FAIL out_lowest: m_valid=%h slice1=%h expected 2 55", m_valid, m_data[BO +: BO]);
    end
    m_ready = 4'b0010;
    tick();
    m_ready = 4'b0000;
    s_valid = 4'b1100;
    s_data[2*BI +: BI] = 19'd9;
    s_data[3*BI +: BI] = 19'd11;
    tick();
    s_valid = 4'b0000;
    req_in = 4'b1100;
    #1;
    nChecks++;
    if (io_in !== 19'd9) begin
      nErrors++;
      $display("[TB] FAIL req_lowest: io_in=%h expected 9", io_in);
    end
    tick();
    req_in = 4'b1000;
    #1;
    nChecks++;
    if (io_in !== 19'd11) begin
      nErrors++;
      $display("[TB] FAIL req_port3_kept: io_in=%h expected b", io_in);
    end
    tick();
    req_in = 4'b0000;
  endtask

  task automatic test_reset_mid();
    s_valid = 4'b0011;
    s_data[0 +: BI] = 19'd21;
    s_data[BI +: BI] = 19'd22;
    out_en = 4'b0010;
    io_out = 28'h0000033;
    tick();
    s_valid = 4'b0000;
    tick();
    out_en = 4'b0000;
    req_in = 4'b0001;
    #1;
    nChecks++;
    if (io_in !== 19'd21 || m_valid !== 4'b0010 || overflow !== (ERR_EN ? 4'b0010 : 4'b0000)) begin
      nErrors++;
      $display("[TB] FAIL pre_reset: io_in=%h m_valid=%h overflow=%h expected 15 2 %h", io_in, m_valid, overflow, ERR_EN ? 4'b0010 : 4'b0000);
    end
    rst = 1'b1;
    #1;
    nChecks++;
    if (s_ready !== 4'hF || m_valid !== 4'h0 || io_in !== '0 || underflow !== 4'h0 || overflow !== 4'h0) begin
      nErrors++;
      $display("[TB] FAIL async_reset: s_ready=%h m_valid=%h io_in=%h underflow=%h overflow=%h expected f 0 0 0 0", s_ready, m_valid, io_in, underflow, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
    req_in = 4'b0010;
    #1;
    nChecks++;
    if (io_in !== '0 || m_data !== '0) begin
      nErrors++;
      $display("[TB] FAIL reset_discard: io_in=%h m_data=%h expected 0 0", io_in, m_data);
    end
    tick();
    req_in = 4'b0000;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    rst     = 1'b1;
    s_data  = '0;
    s_valid = '0;
    req_in  = '0;
    out_en  = '0;
    io_out  = '0;
    m_ready = '0;
    err_clr = 1'b0;
    test_reset();
    test_read_sequence();
    test_full();
    test_capture();
    test_back_to_back();
    test_non_onehot();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
